ram_fifo_ctrl: RTL and testbench

RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

---
 rtl/ram_fifo_ctrl.sv | 124 ++++++++++++
 tb/tb_ram_fifo_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller that stores entries in an external dual-port RAM (port A write, port B read).
// Reads are fetched one entry at a time into a registered output stage.
module ram_fifo_ctrl #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       ram_en_a,
  output logic [$clog2(DEPTH)-1:0]   ram_addr_a,
  output logic [WIDTH-1:0]           ram_data_in_a,
  output logic                       ram_en_b,
  output logic [$clog2(DEPTH)-1:0]   ram_addr_b,
  output logic [WIDTH-1:0]           ram_data_in_b,
  input  logic [WIDTH-1:0]           ram_data_out_b,
  output logic [1:0]                 state_dbg
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  // Handshake: a transfer happens on a rising edge where valid && ready are both high;
  // the sender holds data stable while valid is high and ready is low.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t          state;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   unfetched;
  logic [AW-1:0]   addr_a_q;
  logic [WIDTH-1:0] data_a_q;
  logic            push;
  logic            pop;

  assign full      = (count == PW'(DEPTH));
  assign empty     = (count == '0);
  assign in_ready  = !full;
  // Gated by rst_n so the write strobe is quiet while reset is held.
  assign push      = in_valid && in_ready && rst_n;
  assign pop       = out_valid && out_ready;
  assign unfetched = wr_ptr - rd_ptr;

  assign ram_en_a      = push;
  assign ram_addr_a    = push ? wr_ptr[AW-1:0] : addr_a_q;
  assign ram_data_in_a = push ? in_data : data_a_q;

  // Port B is permanently in read mode (enable low), addressed by the read pointer.
  assign ram_en_b      = 1'b0;
  assign ram_data_in_b = '0;
  assign ram_addr_b    = rd_ptr[AW-1:0];

  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      addr_a_q  <= '0;
      data_a_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + PW'(1);
        addr_a_q <= wr_ptr[AW-1:0];
        data_a_q <= in_data;
      end

      if (push && !pop) begin
        count <= count + PW'(1);
      end else if (pop && !push) begin
        count <= count - PW'(1);
      end

      // unfetched only reflects writes from earlier edges, so a read never targets
      // the address being written in the same cycle.
      case (state)
        IDLE: begin
          if (unfetched != '0) begin
            rd_ptr <= rd_ptr + PW'(1);
            state  <= FETCH;
          end
        end
        FETCH: begin
          out_data  <= ram_data_out_b;
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (pop) begin
            out_valid <= 1'b0;
            if (unfetched != '0) begin
              rd_ptr <= rd_ptr + PW'(1);
              state  <= FETCH;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl: RAM model, queue-based reference, directed scenarios plus random traffic.
module tb_ram_fifo_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [5:0]   count;
  logic         full;
  logic         empty;
  logic         ram_en_a;
  logic [4:0]   ram_addr_a;
  logic [W-1:0] ram_data_in_a;
  logic         ram_en_b;
  logic [4:0]   ram_addr_b;
  logic [W-1:0] ram_data_in_b;
  logic [W-1:0] ram_data_out_b;
  logic [1:0]   state_dbg;

  ram_fifo_ctrl #(.DEPTH(32), .WIDTH(W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .count          (count),
    .full           (full),
    .empty          (empty),
    .ram_en_a       (ram_en_a),
    .ram_addr_a     (ram_addr_a),
    .ram_data_in_a  (ram_data_in_a),
    .ram_en_b       (ram_en_b),
    .ram_addr_b     (ram_addr_b),
    .ram_data_in_b  (ram_data_in_b),
    .ram_data_out_b (ram_data_out_b),
    .state_dbg      (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // 32 x 8 RAM: port A write on enable high, port B synchronous read on enable low
  logic [W-1:0] mem [32];
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
    ram_data_out_b = '0;
  end
  always @(posedge clk) begin
    if (ram_en_a) mem[ram_addr_a] <= ram_data_in_a;
    if (!ram_en_b) ram_data_out_b <= mem[ram_addr_b];
  end

  // scoreboard
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int wr_cnt = 0;
  int pop_cnt = 0;
  int stall = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: check outputs mid-cycle against the model, then apply the edge to the model.
  task automatic step();
    logic push;
    logic pop;
    @(negedge clk);
    check("count", count, exp_q.size());
    check("full", full, exp_q.size() == 32);
    check("empty", empty, exp_q.size() == 0);
    check("in_ready", in_ready, exp_q.size() < 32);
    check("ram_en_b", ram_en_b, 0);
    check("ram_data_in_b", ram_data_in_b, 0);
    push = in_valid && (exp_q.size() < 32);
    pop  = out_valid && out_ready;
    check("ram_en_a", ram_en_a, push);
    if (push) begin
      check("ram_addr_a", ram_addr_a, wr_cnt % 32);
      check("ram_data_in_a", ram_data_in_a, in_data);
    end
    check("valid_without_entry", out_valid && (exp_q.size() == 0), 0);
    if (out_valid && exp_q.size() > 0) begin
      check("out_data", out_data, exp_q[0]);
      check("ram_addr_b_hold", ram_addr_b, (pop_cnt + 1) % 32);
    end
    if (exp_q.size() > 0 && !out_valid) stall++;
    else stall = 0;
    check("fetch_stall", stall <= 2, 1);
    @(posedge clk);
    if (push) begin
      exp_q.push_back(in_data);
      wr_cnt++;
    end
    if (pop && exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      pop_cnt++;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_in_ready", in_ready, 1);
    check("rst_ram_en_a", ram_en_a, 0);
    check("rst_ram_addr_a", ram_addr_a, 0);
    check("rst_ram_data_in_a", ram_data_in_a, 0);
    check("rst_ram_addr_b", ram_addr_b, 0);
    exp_q.delete();
    wr_cnt  = 0;
    pop_cnt = 0;
    stall   = 0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic push_n(input int n, input int base);
    out_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = W'(base + i);
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 300 && exp_q.size() > 0; n++) step();
    check("drain_done", exp_q.size(), 0);
    out_ready = 1'b0;
    step();
  endtask

  task automatic wait_valid();
    for (int n = 0; n < 8 && !out_valid; n++) step();
    check("wait_valid", out_valid, 1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    @(posedge clk);
    do_reset();

    // single entry latency
    in_valid = 1'b1;
    in_data  = 8'hA5;
    step();
    in_valid = 1'b0;
    check("lat_after_n", out_valid, 0);
    step();
    check("lat_after_n1", out_valid, 0);
    step();
    check("lat_after_n2", out_valid, 1);
    check("lat_data", out_data, 8'hA5);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("single_empty", empty, 1);
    check("single_count", count, 0);

    // fill to full, 33rd push ignored, drain in order
    push_n(33, 0);
    check("fill_full", full, 1);
    check("fill_in_ready", in_ready, 0);
    check("fill_count", count, 32);
    drain();

    // wrap-around from a fresh start
    do_reset();
    push_n(20, 8'h40);
    drain();
    push_n(20, 8'h80);
    drain();

    // simultaneous push and pop with count 5
    push_n(5, 8'h10);
    wait_valid();
    in_valid  = 1'b1;
    in_data   = 8'h77;
    out_ready = 1'b1;
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("simul_count", count, 5);
    drain();

    // backpressure in HOLD
    push_n(3, 8'hC0);
    wait_valid();
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) step();
    drain();

    // reset while a fetch is in flight with count 7
    push_n(8, 8'h20);
    wait_valid();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("pre_reset_count", count, 7);
    do_reset();
    in_valid = 1'b1;
    in_data  = 8'h3C;
    step();
    in_valid = 1'b0;
    wait_valid();
    check("post_reset_data", out_data, 8'h3C);
    drain();

    // random traffic with varying pressure
    for (int phase = 0; phase < 4; phase++) begin
      int pv;
      int pr;
      pv = (phase == 0) ? 90 : (phase == 1) ? 30 : 60;
      pr = (phase == 0) ? 20 : (phase == 1) ? 90 : 60;
      for (int c = 0; c < 400; c++) begin
        in_valid  = ($urandom_range(99, 0) < pv);
        in_data   = W'($urandom);
        out_ready = ($urandom_range(99, 0) < pr);
        step();
      end
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
